sdm_reg_bank: RTL and testbench

SDM_REG_BANK -- requirements
Module: sdm_reg_bank

---
 rtl/sdm_reg_bank_if.sv | 36 +++
 rtl/sdm_reg_bank.sv | 259 +++++++++++++++++++++++++
 tb/tb_sdm_reg_bank.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdm_reg_bank_if.sv
// rtl/sdm_reg_bank_if.sv - AXI-lite style register bus for the SDM register bank
interface sdm_reg_bank_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/sdm_reg_bank.sv
// rtl/sdm_reg_bank.sv - per-channel enable/value register bank for the sigma-delta modulators
// Optional build macro SDM_REG_BANK_SHADOW_EN: shadowed CTRL/VALUE with a COMMIT register at 0x80.
module sdm_reg_bank #(
    parameter int NUM_CH      = 4,
    parameter int VALUE_WIDTH = 16
) (
    input  logic                          aclk,
    input  logic                          areset,
    sdm_reg_bank_if.slave                 bus,
    output logic [NUM_CH-1:0]             enable,
    output logic [NUM_CH*VALUE_WIDTH-1:0] value
);

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] INFO_ADDR   = 32'h84;
    localparam logic [31:0] INFO_WORD   = {16'h0, 8'(VALUE_WIDTH), 8'(NUM_CH)};
`ifdef SDM_REG_BANK_SHADOW_EN
    localparam logic [31:0] COMMIT_ADDR = 32'h80;
`endif

    typedef enum logic [1:0] {W_IDLE, W_WAIT_ADDR, W_WAIT_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;

    // Live registers drive the modulator outputs.
    logic [NUM_CH-1:0]      ctrl_q;
    logic [VALUE_WIDTH-1:0] val_q [NUM_CH];
`ifdef SDM_REG_BANK_SHADOW_EN
    logic [NUM_CH-1:0]      ctrl_sh;
    logic [VALUE_WIDTH-1:0] val_sh [NUM_CH];
`endif

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

    // ---------------- write path ----------------
    logic        aw_hs, w_hs, wr_fire;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic [NUM_CH-1:0] wr_ctrl_sel, wr_val_sel;
    logic        wr_commit_sel, wr_ok;

    assign aw_hs = bus.awvalid & awready_q;
    assign w_hs  = bus.wvalid & wready_q;

    // Whichever half arrived first comes from the latch, the other straight off the bus.
    assign wr_addr = (w_state == W_WAIT_DATA) ? aw_addr_q : bus.awaddr;
    assign wr_data = (w_state == W_WAIT_ADDR) ? w_data_q  : bus.wdata;
    assign wr_strb = (w_state == W_WAIT_ADDR) ? w_strb_q  : bus.wstrb;

    always_comb begin
        wr_fire = 1'b0;
        unique case (w_state)
            W_IDLE:      wr_fire = aw_hs & w_hs;
            W_WAIT_ADDR: wr_fire = aw_hs;
            W_WAIT_DATA: wr_fire = w_hs;
            default:     wr_fire = 1'b0;
        endcase
    end

    always_comb begin
        wr_ctrl_sel = '0;
        wr_val_sel  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ctrl_sel[c] = (wr_addr == 32'(8*c));
            wr_val_sel[c]  = (wr_addr == 32'(8*c + 4));
        end
    end

`ifdef SDM_REG_BANK_SHADOW_EN
    assign wr_commit_sel = (wr_addr == COMMIT_ADDR);
`else
    assign wr_commit_sel = 1'b0;
`endif

    // INFO is read-only, so it deliberately stays out of the write-ok set.
    assign wr_ok = (|wr_ctrl_sel) | (|wr_val_sel) | wr_commit_sel;

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (wr_fire) begin
            w_state   <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= bus.awaddr;
                        awready_q <= 1'b0;
                        w_state   <= W_WAIT_DATA;
                    end else if (w_hs) begin
                        w_data_q <= bus.wdata;
                        w_strb_q <= bus.wstrb;
                        wready_q <= 1'b0;
                        w_state  <= W_WAIT_ADDR;
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SDM_REG_BANK_SHADOW_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            ctrl_sh <= '0;
            ctrl_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                val_sh[c] <= '0;
                val_q[c]  <= '0;
            end
        end else if (wr_fire) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_ctrl_sel[c] && wr_strb[0])
                    ctrl_sh[c] <= wr_data[0];
                if (wr_val_sel[c])
                    val_sh[c] <= merge_bytes(32'(val_sh[c]), wr_data, wr_strb)[VALUE_WIDTH-1:0];
            end
            // All channels switch together so the modulators never see a half-applied update.
            if (wr_commit_sel && wr_strb[0] && wr_data[0]) begin
                ctrl_q <= ctrl_sh;
                for (int c = 0; c < NUM_CH; c++)
                    val_q[c] <= val_sh[c];
            end
        end
    end
`else
    always_ff @(posedge aclk) begin
        if (areset) begin
            ctrl_q <= '0;
            for (int c = 0; c < NUM_CH; c++)
                val_q[c] <= '0;
        end else if (wr_fire) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_ctrl_sel[c] && wr_strb[0])
                    ctrl_q[c] <= wr_data[0];
                if (wr_val_sel[c])
                    val_q[c] <= merge_bytes(32'(val_q[c]), wr_data, wr_strb)[VALUE_WIDTH-1:0];
            end
        end
    end
`endif

    always_comb begin
        enable = ctrl_q;
        value  = '0;
        for (int c = 0; c < NUM_CH; c++)
            value[c*VALUE_WIDTH +: VALUE_WIDTH] = val_q[c];
    end

    // ---------------- read path ----------------
    logic [31:0] rd_word;
    logic        rd_ok;

    always_comb begin
        rd_word = '0;
        rd_ok   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.araddr == 32'(8*c)) begin
                rd_ok = 1'b1;
`ifdef SDM_REG_BANK_SHADOW_EN
                rd_word = {31'h0, ctrl_sh[c]};
`else
                rd_word = {31'h0, ctrl_q[c]};
`endif
            end else if (bus.araddr == 32'(8*c + 4)) begin
                rd_ok = 1'b1;
`ifdef SDM_REG_BANK_SHADOW_EN
                rd_word = 32'(val_sh[c]);
`else
                rd_word = 32'(val_q[c]);
`endif
            end
        end
        if (bus.araddr == INFO_ADDR) begin
            rd_ok   = 1'b1;
            rd_word = INFO_WORD;
        end
`ifdef SDM_REG_BANK_SHADOW_EN
        if (bus.araddr == COMMIT_ADDR)
            rd_ok = 1'b1;
`endif
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (bus.arvalid && arready_q) begin
                        rdata_q   <= rd_word;
                        rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdm_reg_bank.sv
// tb/tb_sdm_reg_bank.sv - scoreboard bench for sdm_reg_bank (NUM_CH=4, VALUE_WIDTH=16)
module tb_sdm_reg_bank;
    localparam int NUM_CH = 4;
    localparam int VW     = 16;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    sdm_reg_bank_if bus();
    logic [NUM_CH-1:0]    enable;
    logic [NUM_CH*VW-1:0] value;

    sdm_reg_bank #(.NUM_CH(NUM_CH), .VALUE_WIDTH(VW)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus.slave),
        .enable (enable),
        .value  (value)
    );

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic          m_ctrl  [NUM_CH];
    logic          m_sctrl [NUM_CH];
    logic [VW-1:0] m_val   [NUM_CH];
    logic [VW-1:0] m_sval  [NUM_CH];
    logic [1:0]    bq [$];
    rsp_t          rq [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_enable();
        logic [63:0] r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) r[c] = m_ctrl[c];
        return r;
    endfunction

    function automatic logic [63:0] m_value();
        logic [63:0] r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) r[c*VW +: VW] = m_val[c];
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_ctrl[c] = 1'b0; m_sctrl[c] = 1'b0;
            m_val[c]  = '0;   m_sval[c]  = '0;
        end
        bq.delete();
        rq.delete();
    endtask

    task automatic exp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0]  resp;
        logic [31:0] w;
        resp = 2'b10;
        for (int c = 0; c < NUM_CH; c++) begin
            if (a == 32'(8*c)) begin
                resp = 2'b00;
                if (s[0]) m_sctrl[c] = d[0];
            end else if (a == 32'(8*c + 4)) begin
                resp = 2'b00;
                w = 32'(m_sval[c]);
                for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
                m_sval[c] = w[VW-1:0];
            end
        end
`ifdef SDM_REG_BANK_SHADOW_EN
        if (a == 32'h80) begin
            resp = 2'b00;
            if (s[0] && d[0])
                for (int c = 0; c < NUM_CH; c++) begin
                    m_ctrl[c] = m_sctrl[c]; m_val[c] = m_sval[c];
                end
        end
`else
        for (int c = 0; c < NUM_CH; c++) begin
            m_ctrl[c] = m_sctrl[c]; m_val[c] = m_sval[c];
        end
`endif
        bq.push_back(resp);
    endtask

    task automatic exp_read(input logic [31:0] a);
        rsp_t r;
        r.resp = 2'b10;
        r.data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (a == 32'(8*c))         begin r.resp = 2'b00; r.data = {31'h0, m_sctrl[c]}; end
            else if (a == 32'(8*c + 4)) begin r.resp = 2'b00; r.data = 32'(m_sval[c]); end
        end
        if (a == 32'h84) begin r.resp = 2'b00; r.data = 32'h0000_1004; end
`ifdef SDM_REG_BANK_SHADOW_EN
        if (a == 32'h80) begin r.resp = 2'b00; r.data = '0; end
`endif
        rq.push_back(r);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_aw(input logic [31:0] a);
        logic hs;
        int   n;
        hs = 1'b0; n = 0;
        bus.awaddr = a; bus.awvalid = 1'b1;
        while (!hs && n < 50) begin hs = bus.awready; step(); n++; end
        bus.awvalid = 1'b0;
        if (!hs) check_eq("aw_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        logic hs;
        int   n;
        hs = 1'b0; n = 0;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        while (!hs && n < 50) begin hs = bus.wready; step(); n++; end
        bus.wvalid = 1'b0;
        if (!hs) check_eq("w_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_p, w_p, aw_h, w_h;
        int   n;
        n = 0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        aw_p = 1'b1; w_p = 1'b1;
        while ((aw_p || w_p) && n < 50) begin
            aw_h = aw_p && bus.awready;
            w_h  = w_p && bus.wready;
            step(); n++;
            if (aw_h) begin aw_p = 1'b0; bus.awvalid = 1'b0; end
            if (w_h)  begin w_p  = 1'b0; bus.wvalid  = 1'b0; end
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (aw_p || w_p) check_eq("aw_w_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_ar(input logic [31:0] a);
        logic hs;
        int   n;
        hs = 1'b0; n = 0;
        bus.araddr = a; bus.arvalid = 1'b1;
        while (!hs && n < 50) begin hs = bus.arready; step(); n++; end
        bus.arvalid = 1'b0;
        if (!hs) check_eq("ar_timeout", 64'd0, 64'd1);
    endtask

    task automatic get_b(input int hold);
        logic [1:0] exp;
        int n;
        exp = 2'b00; n = 0;
        while (!bus.bvalid && n < 50) begin step(); n++; end
        if (!bus.bvalid) begin
            check_eq("b_timeout", 64'd0, 64'd1);
            return;
        end
        if (bq.size() == 0) check_eq("b_unexpected", 64'd1, 64'd0);
        else begin
            exp = bq.pop_front();
            check_eq("bresp", 64'(bus.bresp), 64'(exp));
        end
        check_eq("enable", 64'(enable), m_enable());
        check_eq("value", 64'(value), m_value());
        for (int i = 0; i < hold; i++) begin
            step();
            check_eq("bvalid_hold", 64'(bus.bvalid), 64'd1);
            check_eq("bresp_hold", 64'(bus.bresp), 64'(exp));
        end
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check_eq("bvalid_clr", 64'(bus.bvalid), 64'd0);
    endtask

    task automatic get_r();
        rsp_t exp;
        int n;
        n = 0;
        while (!bus.rvalid && n < 50) begin step(); n++; end
        if (!bus.rvalid) begin
            check_eq("r_timeout", 64'd0, 64'd1);
            return;
        end
        if (rq.size() == 0) check_eq("r_unexpected", 64'd1, 64'd0);
        else begin
            exp = rq.pop_front();
            check_eq("rresp", 64'(bus.rresp), 64'(exp.resp));
            check_eq("rdata", 64'(bus.rdata), 64'(exp.data));
        end
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        check_eq("rvalid_clr", 64'(bus.rvalid), 64'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_write(a, d, s);
        do_aw_w(a, d, s);
        check_eq("b_latency", 64'(bus.bvalid), 64'd1);
        get_b(0);
    endtask

    task automatic rd(input logic [31:0] a);
        exp_read(a);
        do_ar(a);
        check_eq("r_latency", 64'(bus.rvalid), 64'd1);
        get_r();
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_awready"}, 64'(bus.awready), 64'd1);
        check_eq({tag, "_wready"},  64'(bus.wready),  64'd1);
        check_eq({tag, "_arready"}, 64'(bus.arready), 64'd1);
        check_eq({tag, "_bvalid"},  64'(bus.bvalid),  64'd0);
        check_eq({tag, "_rvalid"},  64'(bus.rvalid),  64'd0);
        check_eq({tag, "_rdata"},   64'(bus.rdata),   64'd0);
        check_eq({tag, "_enable"},  64'(enable),      64'd0);
        check_eq({tag, "_value"},   64'(value),       64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        model_reset();
        areset = 1'b1;
        repeat (3) step();
        areset = 1'b0;
        check_idle("reset");

        // Simultaneous AW+W to VALUE(1)
        wr(32'h0C, 32'h0001_ABCD, 4'hF);

        // W leads AW by three cycles; response held for five cycles
        exp_write(32'h08, 32'h1, 4'hF);
        do_w(32'h1, 4'hF);
        for (int i = 0; i < 3; i++) begin
            check_eq("wfirst_awready", 64'(bus.awready), 64'd1);
            check_eq("wfirst_wready",  64'(bus.wready),  64'd0);
            check_eq("wfirst_bvalid",  64'(bus.bvalid),  64'd0);
            if (i < 2) step();
        end
        do_aw(32'h08);
        get_b(5);

        // AW leads W
        exp_write(32'h1C, 32'h0000_7E57, 4'hF);
        do_aw(32'h1C);
        check_eq("awfirst_wready",  64'(bus.wready),  64'd1);
        check_eq("awfirst_awready", 64'(bus.awready), 64'd0);
        step();
        do_w(32'h0000_7E57, 4'hF);
        get_b(0);

        // Unmapped / read-only writes and reads
        wr(32'h24, 32'hFFFF_FFFF, 4'hF);
        wr(32'h86, 32'hFFFF_FFFF, 4'hF);
        wr(32'h84, 32'hFFFF_FFFF, 4'hF);
        wr(32'h02, 32'hFFFF_FFFF, 4'hF);
        rd(32'h84);
        rd(32'h90);
        rd(32'h0C);
        rd(32'h08);

        // Byte strobes
        wr(32'h04, 32'h0000_1234, 4'hF);
        wr(32'h04, 32'h0000_5678, 4'b0010);
        rd(32'h04);
        wr(32'h04, 32'hDEAD_BEEF, 4'b0000);
        rd(32'h04);
        wr(32'h00, 32'h0000_0003, 4'b0010);
        rd(32'h00);

        // Shadow and commit (0x80 is unmapped without the shadow build)
        wr(32'h14, 32'h0000_00FF, 4'hF);
        rd(32'h14);
        wr(32'h10, 32'h1, 4'hF);
        rd(32'h80);
        wr(32'h80, 32'h1, 4'hF);
        rd(32'h14);

        // Read and write to the same register on the same edge
        exp_read(32'h04);
        exp_write(32'h04, 32'h0000_BEEF, 4'hF);
        check_eq("rw_ready", 64'({bus.awready, bus.wready, bus.arready}), 64'd7);
        bus.awaddr = 32'h04; bus.wdata = 32'h0000_BEEF; bus.wstrb = 4'hF; bus.araddr = 32'h04;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        get_b(0);
        get_r();
        rd(32'h04);

        // Reset while a write waits for data and a read waits for rready
        bus.awaddr = 32'h04; bus.awvalid = 1'b1;
        bus.araddr = 32'h00; bus.arvalid = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        check_eq("pre_rst_rvalid", 64'(bus.rvalid), 64'd1);
        areset = 1'b1;
        step();
        areset = 1'b0;
        model_reset();
        check_idle("midrst");
        exp_write(32'h0C, 32'h0000_5A5A, 4'hF);
        do_w(32'h0000_5A5A, 4'hF);
        check_eq("midrst_waddr_awready", 64'(bus.awready), 64'd1);
        check_eq("midrst_waddr_wready",  64'(bus.wready),  64'd0);
        do_aw(32'h0C);
        get_b(0);
        rd(32'h0C);
        rd(32'h04);
        rd(32'h08);

        check_eq("bq_empty", 64'(bq.size()), 64'd0);
        check_eq("rq_empty", 64'(rq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
